// File: rtl/sng_pkg.sv
// Shared types and defaults for the stochastic-number stream scheduler.
package sng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WARM,
    RUN,
    STOP
  } sch_state_t;

  localparam int SNG_XW         = 4;
  localparam int SNG_STREAM_LEN = 16;

endpackage

// File: rtl/sn_operand_shadow.sv
// One-deep operand holding register with full flag; ready also opens on the draining cycle.
module sn_operand_shadow
  import sng_pkg::*;
#(
  parameter int W = 8 * SNG_XW
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_drain,
  input  logic         i_clear,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_ready
);

  logic         r_full;
  logic [W-1:0] r_data;

  // Clear outranks a load; a load on the draining cycle keeps the register full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_full  = r_full;
  assign o_ready = !r_full || i_drain;

endmodule

// File: rtl/sn_stream_sched.sv
// Sequencer for a bank of SNG lanes: shadowed operand intake, start/stop pulses, bit-window timing.
// Defining SNG_SCHED_PERF_EN adds saturating completed-stream and abort counters as outputs.
module sn_stream_sched
  import sng_pkg::*;
#(
  parameter int N_LANE     = 8,
  parameter int XW         = SNG_XW,
  parameter int STREAM_LEN = SNG_STREAM_LEN,
  parameter int START_LAT  = 2,
  parameter int CNT_W      = $clog2(STREAM_LEN)
) (
  input  logic                 i_clk_sch,
  input  logic                 i_rst_sch,
  input  logic                 i_x_valid,
  output logic                 o_x_ready,
  input  logic [N_LANE*XW-1:0] i_x_data,
  input  logic                 i_abort,
  output logic [N_LANE*XW-1:0] o_lane_x,
  output logic                 o_lane_start,
  output logic                 o_lane_stop,
  output logic                 o_bit_valid,
  output logic                 o_bit_last,
  output logic                 o_busy
`ifdef SNG_SCHED_PERF_EN
  ,
  output logic [15:0]          o_stream_cnt,
  output logic [15:0]          o_abort_cnt
`endif
);

  localparam int DW     = N_LANE * XW;
  localparam int WARM_W = (START_LAT > 1) ? $clog2(START_LAT) : 1;

  sch_state_t        r_state;
  sch_state_t        w_state_nxt;
  logic [WARM_W-1:0] r_warm;
  logic [CNT_W-1:0]  r_bit;
  logic [DW-1:0]     r_lane_x;
  logic [DW-1:0]     w_shadow_x;
  logic              w_shadow_full;
  logic              w_shadow_load;
  logic              w_drain;

  // Abort drops a vector offered on the same cycle.
  assign w_shadow_load = i_x_valid && o_x_ready && !i_abort;

  sn_operand_shadow #(
    .W (DW)
  ) u_shadow (
    .i_clk   (i_clk_sch),
    .i_rst   (i_rst_sch),
    .i_load  (w_shadow_load),
    .i_data  (i_x_data),
    .i_drain (w_drain),
    .i_clear (i_abort),
    .o_data  (w_shadow_x),
    .o_full  (w_shadow_full),
    .o_ready (o_x_ready)
  );

  always_ff @(posedge i_clk_sch or posedge i_rst_sch) begin
    if (i_rst_sch) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The bit counter restarts on every entry to RUN, so it never wraps within a stream.
  always_ff @(posedge i_clk_sch or posedge i_rst_sch) begin
    if (i_rst_sch) begin
      r_warm <= '0;
      r_bit  <= '0;
    end else begin
      if (r_state == START) begin
        r_warm <= WARM_W'(START_LAT - 1);
      end else if (r_state == WARM && r_warm != '0) begin
        r_warm <= r_warm - 1'b1;
      end
      if (r_state == RUN) begin
        r_bit <= r_bit + 1'b1;
      end else begin
        r_bit <= '0;
      end
    end
  end

  always_ff @(posedge i_clk_sch or posedge i_rst_sch) begin
    if (i_rst_sch) begin
      r_lane_x <= '0;
    end else if (w_drain) begin
      r_lane_x <= w_shadow_x;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain      = 1'b0;
    o_lane_start = 1'b0;
    o_lane_stop  = 1'b0;
    o_bit_valid  = 1'b0;
    o_bit_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_shadow_full && !i_abort) begin
          w_drain     = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        o_lane_start = 1'b1;
        w_state_nxt  = i_abort ? STOP : WARM;
      end
      WARM: begin
        if (i_abort) begin
          w_state_nxt = STOP;
        end else if (r_warm == '0) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          w_state_nxt = STOP;
        end else begin
          o_bit_valid = 1'b1;
          if (r_bit == CNT_W'(STREAM_LEN - 1)) begin
            o_bit_last  = 1'b1;
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        o_lane_stop = 1'b1;
        if (w_shadow_full && !i_abort) begin
          w_drain     = 1'b1;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_lane_x = r_lane_x;
  assign o_busy   = (r_state != IDLE);

`ifdef SNG_SCHED_PERF_EN
  logic        w_kill;
  logic [15:0] r_stream_cnt;
  logic [15:0] r_abort_cnt;

  assign w_kill = i_abort && (r_state == START || r_state == WARM || r_state == RUN);

  always_ff @(posedge i_clk_sch or posedge i_rst_sch) begin
    if (i_rst_sch) begin
      r_stream_cnt <= '0;
      r_abort_cnt  <= '0;
    end else begin
      if (o_bit_last && r_stream_cnt != 16'hFFFF) begin
        r_stream_cnt <= r_stream_cnt + 16'd1;
      end
      if (w_kill && r_abort_cnt != 16'hFFFF) begin
        r_abort_cnt <= r_abort_cnt + 16'd1;
      end
    end
  end

  assign o_stream_cnt = r_stream_cnt;
  assign o_abort_cnt  = r_abort_cnt;
`endif

endmodule

// File: tb/tb_sn_stream_sched.sv
// Self-checking bench for sn_stream_sched; a scoreboard of accepted vectors is matched at each lane start.
module tb_sn_stream_sched;

  localparam int N_LANE     = 8;
  localparam int XW         = 4;
  localparam int STREAM_LEN = 16;
  localparam int START_LAT  = 2;
  localparam int DW         = N_LANE * XW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_x_valid;
  logic          i_abort;
  logic [DW-1:0] i_x_data;
  logic          o_x_ready;
  logic [DW-1:0] o_lane_x;
  logic          o_lane_start;
  logic          o_lane_stop;
  logic          o_bit_valid;
  logic          o_bit_last;
  logic          o_busy;
`ifdef SNG_SCHED_PERF_EN
  logic [15:0]   o_stream_cnt;
  logic [15:0]   o_abort_cnt;
`endif

  int            n_checks = 0;
  int            n_pass = 0;
  int            streams_done = 0;
  logic [DW-1:0] sb[$];
  bit            mon_in = 0;
  int            mon_bits = 0;
  logic [DW-1:0] mon_x = '0;

  always #5 clk = ~clk;

  sn_stream_sched #(
    .N_LANE     (N_LANE),
    .XW         (XW),
    .STREAM_LEN (STREAM_LEN),
    .START_LAT  (START_LAT)
  ) dut (
    .i_clk_sch    (clk),
    .i_rst_sch    (rst),
    .i_x_valid    (i_x_valid),
    .o_x_ready    (o_x_ready),
    .i_x_data     (i_x_data),
    .i_abort      (i_abort),
    .o_lane_x     (o_lane_x),
    .o_lane_start (o_lane_start),
    .o_lane_stop  (o_lane_stop),
    .o_bit_valid  (o_bit_valid),
    .o_bit_last   (o_bit_last),
    .o_busy       (o_busy)
`ifdef SNG_SCHED_PERF_EN
    ,
    .o_stream_cnt (o_stream_cnt),
    .o_abort_cnt  (o_abort_cnt)
`endif
  );

  // Scoreboard side: each start pulse must present the oldest accepted vector.
  always @(negedge clk) begin
    if (rst) begin
      mon_in   = 0;
      mon_bits = 0;
    end else begin
      if (o_lane_start) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_start: start pulse with no pending vector, lane_x=%h", o_lane_x);
        end else begin
          mon_x = sb.pop_front();
          if (o_lane_x !== mon_x) $display("FAIL sb_lane_x: got %h expected %h", o_lane_x, mon_x);
          else n_pass++;
        end
        mon_in   = 1;
        mon_bits = 0;
      end
      if (o_bit_valid) begin
        mon_bits++;
        n_checks++;
        if (!mon_in || o_lane_x !== mon_x)
          $display("FAIL lane_stable: lane_x=%h expected %h in_stream=%0d", o_lane_x, mon_x, mon_in);
        else n_pass++;
      end
      if (o_bit_last) begin
        n_checks++;
        if (!o_bit_valid || mon_bits != STREAM_LEN)
          $display("FAIL last_len: bits=%0d valid=%b expected %0d valid=1", mon_bits, o_bit_valid, STREAM_LEN);
        else n_pass++;
        streams_done++;
      end
      if (o_lane_stop) mon_in = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v, input int max_cyc, output int waited);
    i_x_valid = 1'b1;
    i_x_data  = v;
    waited    = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (o_x_ready) begin
        sb.push_back(v);
        waited = i;
        step();
        break;
      end
      step();
    end
    i_x_valid = 1'b0;
    i_x_data  = DW'($urandom);
  endtask

  task automatic test_reset();
    i_x_valid = 1'b0;
    i_abort   = 1'b0;
    i_x_data  = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_x_ready, o_busy, o_lane_start, o_lane_stop, o_bit_valid, o_bit_last} !== 6'b100000 || o_lane_x !== '0)
      $display("FAIL reset_vals: rdy/busy/start/stop/valid/last=%b lane_x=%h expected 100000 0",
               {o_x_ready, o_busy, o_lane_start, o_lane_stop, o_bit_valid, o_bit_last}, o_lane_x);
    else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i_x_data = DW'($urandom);
      @(negedge clk);
      n_checks++;
      if ({o_x_ready, o_busy, o_lane_start, o_lane_stop, o_bit_valid, o_bit_last} !== 6'b100000)
        $display("FAIL idle_c%0d: rdy/busy/start/stop/valid/last=%b expected 100000", k,
                 {o_x_ready, o_busy, o_lane_start, o_lane_stop, o_bit_valid, o_bit_last});
      else n_pass++;
      step();
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] v = 32'h8765_4321;
    int w, sk, vs, ve, sp;
    sk = 2;
    vs = sk + START_LAT + 1;
    ve = vs + STREAM_LEN - 1;
    sp = ve + 1;
    send(v, 4, w);
    n_checks++;
    if (w != 0) $display("FAIL single_accept: waited %0d expected 0", w);
    else n_pass++;
    for (int k = 1; k <= sp + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_lane_start !== (k == sk) || o_bit_valid !== (k >= vs && k <= ve) || o_bit_last !== (k == ve) ||
          o_lane_stop !== (k == sp) || o_busy !== (k >= sk && k <= sp) || (k >= sk && k <= sp && o_lane_x !== v))
        $display("FAIL single_c%0d: start=%b valid=%b last=%b stop=%b busy=%b x=%h expected %b %b %b %b %b %h", k,
                 o_lane_start, o_bit_valid, o_bit_last, o_lane_stop, o_busy, o_lane_x,
                 (k == sk), (k >= vs && k <= ve), (k == ve), (k == sp), (k >= sk && k <= sp), v);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v1 = 32'hA5A5_0F0F;
    logic [DW-1:0] v2 = 32'h1357_9BDF;
    int w, t_last1, t_stop1, t_start2, t_v2, nvalid, sd0;
    t_last1 = -1; t_stop1 = -1; t_start2 = -1; t_v2 = -1; nvalid = 0;
    sd0 = streams_done;
    send(v1, 4, w);
    for (int k = 1; k <= 70; k++) begin
      if (k == 10) begin
        i_x_valid = 1'b1;
        i_x_data  = v2;
      end
      @(negedge clk);
      if (k == 10) begin
        n_checks++;
        if (o_x_ready !== 1'b1 || o_bit_valid !== 1'b1)
          $display("FAIL b2b_accept: ready=%b valid=%b expected 1 1", o_x_ready, o_bit_valid);
        else n_pass++;
        if (o_x_ready) sb.push_back(v2);
      end
      if (o_bit_last && t_last1 < 0) t_last1 = k;
      if (o_lane_stop && t_stop1 < 0) t_stop1 = k;
      if (o_lane_start && k > 2 && t_start2 < 0) t_start2 = k;
      if (o_bit_valid && t_last1 >= 0 && k > t_last1 && t_v2 < 0) t_v2 = k;
      if (o_bit_valid) nvalid++;
      step();
      if (k == 10) i_x_valid = 1'b0;
    end
    n_checks++;
    if (t_stop1 != t_last1 + 1 || t_start2 != t_stop1 + 1)
      $display("FAIL b2b_pulses: last=%0d stop=%0d start2=%0d expected stop=last+1 start2=stop+1", t_last1, t_stop1, t_start2);
    else n_pass++;
    n_checks++;
    if (t_v2 - t_last1 - 1 != 2 + START_LAT)
      $display("FAIL b2b_gap: gap=%0d expected %0d", t_v2 - t_last1 - 1, 2 + START_LAT);
    else n_pass++;
    n_checks++;
    if (nvalid != 2 * STREAM_LEN || streams_done - sd0 != 2)
      $display("FAIL b2b_count: valid=%0d streams=%0d expected %0d 2", nvalid, streams_done - sd0, 2 * STREAM_LEN);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vv[3];
    int acc[3];
    int idx, t_stop1, low_cyc, sd0;
    vv[0] = 32'h0BAD_F00D;
    vv[1] = 32'hCAFE_1234;
    vv[2] = 32'h5EED_7788;
    idx = 0; t_stop1 = -1; low_cyc = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    sd0 = streams_done;
    for (int k = 0; k <= 100; k++) begin
      if (idx < 3) begin
        i_x_valid = 1'b1;
        i_x_data  = vv[idx];
      end else begin
        i_x_valid = 1'b0;
      end
      @(negedge clk);
      if (o_lane_stop && t_stop1 < 0) t_stop1 = k;
      if (idx < 3) begin
        if (o_x_ready) begin
          sb.push_back(vv[idx]);
          acc[idx] = k;
          idx++;
        end else begin
          low_cyc++;
        end
      end
      step();
    end
    i_x_valid = 1'b0;
    n_checks++;
    if (idx != 3 || acc[2] != t_stop1 || low_cyc == 0)
      $display("FAIL bp_third: accepted=%0d third_at=%0d stop1_at=%0d low=%0d expected 3, third at stop1, low>0",
               idx, acc[2], t_stop1, low_cyc);
    else n_pass++;
    n_checks++;
    if (streams_done - sd0 != 3 || sb.size() != 0)
      $display("FAIL bp_streams: streams=%0d left=%0d expected 3 0", streams_done - sd0, sb.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [DW-1:0] v1 = 32'h1111_2222;
    logic [DW-1:0] v2 = 32'h3333_4444;
    int w, k_ab, sd0;
    bit stray;
`ifdef SNG_SCHED_PERF_EN
    logic [15:0] sc0, ac0;
    sc0 = o_stream_cnt;
    ac0 = o_abort_cnt;
`endif
    stray = 0;
    k_ab  = 2 + START_LAT + 1 + 5;
    sd0   = streams_done;
    send(v1, 4, w);
    for (int k = 1; k <= 30; k++) begin
      if (k == 8) begin
        i_x_valid = 1'b1;
        i_x_data  = v2;
      end
      i_abort = (k == k_ab);
      @(negedge clk);
      if (k == 8 && o_x_ready) sb.push_back(v2);
      if (k == k_ab - 1) begin
        n_checks++;
        if (o_bit_valid !== 1'b1) $display("FAIL abort_pre: valid=%b expected 1", o_bit_valid);
        else n_pass++;
      end
      if (k == k_ab) begin
        n_checks++;
        if (o_bit_valid !== 1'b0 || o_bit_last !== 1'b0 || o_lane_stop !== 1'b0)
          $display("FAIL abort_cyc: valid=%b last=%b stop=%b expected 0 0 0", o_bit_valid, o_bit_last, o_lane_stop);
        else n_pass++;
      end
      if (k == k_ab + 1) begin
        n_checks++;
        if (o_lane_stop !== 1'b1 || o_bit_valid !== 1'b0)
          $display("FAIL abort_stop: stop=%b valid=%b expected 1 0", o_lane_stop, o_bit_valid);
        else n_pass++;
      end
      if (k == k_ab + 2) begin
        n_checks++;
        if (o_busy !== 1'b0 || o_x_ready !== 1'b1)
          $display("FAIL abort_idle: busy=%b ready=%b expected 0 1", o_busy, o_x_ready);
        else n_pass++;
      end
      if (k > k_ab + 1 && (o_bit_valid || o_lane_start || o_bit_last)) stray = 1;
      step();
      if (k == 8) i_x_valid = 1'b0;
      if (k == k_ab) sb.delete();
    end
    i_abort = 1'b0;
    n_checks++;
    if (stray || streams_done != sd0)
      $display("FAIL abort_after: stray_activity=%0d streams=%0d expected 0 0", stray, streams_done - sd0);
    else n_pass++;
`ifdef SNG_SCHED_PERF_EN
    n_checks++;
    if (o_abort_cnt !== ac0 + 16'd1 || o_stream_cnt !== sc0)
      $display("FAIL abort_perf: abort_cnt=%0d stream_cnt=%0d expected %0d %0d", o_abort_cnt, o_stream_cnt, ac0 + 16'd1, sc0);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] v1 = 32'h2468_ACE0;
    logic [DW-1:0] v2 = 32'hFEDC_BA98;
    int w, nv, nl;
    send(v1, 4, w);
    step();
    step();
    #2;
    n_checks++;
    if (o_busy !== 1'b1 || o_bit_valid !== 1'b0 || o_lane_start !== 1'b0)
      $display("FAIL arst_warm: busy=%b valid=%b start=%b expected 1 0 0", o_busy, o_bit_valid, o_lane_start);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_x_ready, o_busy, o_lane_start, o_lane_stop, o_bit_valid, o_bit_last} !== 6'b100000 || o_lane_x !== '0)
      $display("FAIL arst_vals: rdy/busy/start/stop/valid/last=%b lane_x=%h expected 100000 0",
               {o_x_ready, o_busy, o_lane_start, o_lane_stop, o_bit_valid, o_bit_last}, o_lane_x);
    else n_pass++;
`ifdef SNG_SCHED_PERF_EN
    n_checks++;
    if (o_stream_cnt !== 16'd0 || o_abort_cnt !== 16'd0)
      $display("FAIL arst_perf: stream_cnt=%0d abort_cnt=%0d expected 0 0", o_stream_cnt, o_abort_cnt);
    else n_pass++;
`endif
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    step();
    nv = 0;
    nl = 0;
    send(v2, 4, w);
    n_checks++;
    if (w != 0) $display("FAIL arst_accept: waited %0d expected 0", w);
    else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_bit_valid) nv++;
      if (o_bit_last) nl++;
      step();
    end
    n_checks++;
    if (nv != STREAM_LEN || nl != 1)
      $display("FAIL arst_stream: valid=%0d last=%0d expected %0d 1", nv, nl, STREAM_LEN);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  initial begin
    i_x_valid = 1'b0;
    i_abort   = 1'b0;
    i_x_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_async_reset();
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sn_stream_sched.md
Name: sn_stream_sched

Overview:
- Sequencer for a bank of N_LANE stochastic number generator lanes.
- Accepts a vector of 4-bit binary operands through a valid/ready handshake and holds it in a shadow register, so the next vector can be accepted while the current stream runs.
- Broadcasts start/stop pulses to all lanes, times the STREAM_LEN-bit window, and tells the downstream stochastic accumulator which cycles carry valid stream bits and which is the last.

Parameters:
N_LANE, 8, number of SNG lanes driven in lockstep
XW, 4, binary operand width per lane
STREAM_LEN, 16, stream bits per operand (2^XW)
START_LAT, 2, cycles from o_lane_start pulse to first valid lane bit
CNT_W, $clog2(STREAM_LEN), stream bit counter width

Ports:
i_clk_sch  in  1  clock
i_rst_sch  in  1  asynchronous reset, active-high
i_x_valid  in  1  operand vector valid
o_x_ready  out  1  shadow register empty, can accept
i_x_data  in  N_LANE*XW  operand vector, lane k at [k*XW+:XW]
i_abort  in  1  kill current stream and drop the shadow vector
o_lane_x  out  N_LANE*XW  operand held stable to lanes for the whole window
o_lane_start  out  1  one-cycle start pulse to all lanes
o_lane_stop  out  1  one-cycle stop pulse to all lanes
o_bit_valid  out  1  lane output bits valid this cycle
o_bit_last  out  1  final bit of the stream (qualified by o_bit_valid)
o_busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0 except o_x_ready = 1; shadow empty; counters 0; state IDLE.
- Reset asserted mid-stream returns everything to these values immediately (asynchronous).
- Handshake: a transfer occurs when i_x_valid && o_x_ready on a rising edge. i_x_data is captured into the shadow register, and o_x_ready drops the next cycle. i_x_data is don't-care when i_x_valid = 0.
- States: IDLE, START, WARM, RUN, STOP.
- IDLE: if the shadow is full, copy shadow to o_lane_x, mark shadow empty, go to START.
- START: o_lane_start = 1 for exactly this cycle; load the warm counter to START_LAT-1; go to WARM.
- WARM: decrement the warm counter; at 0 go to RUN with the bit counter at 0. When START_LAT = 1, WARM lasts one cycle.
- RUN:
  - o_bit_valid = 1 and the bit counter increments every cycle.
  - o_bit_last = 1 when bit counter = STREAM_LEN-1; the next state is then STOP.
  - Exactly STREAM_LEN valid cycles per operand.
- STOP:
  - o_lane_stop = 1 for one cycle.
  - If the shadow is full, copy it to o_lane_x and go directly to START (back-to-back). Otherwise go to IDLE.
  - Gap between consecutive streams: STOP + START + WARM = 2 + START_LAT cycles of o_bit_valid = 0.
- o_lane_x changes only on the IDLE->START or STOP->START copy and is stable throughout START/WARM/RUN/STOP.
- o_x_ready = !shadow_full. A transfer is allowed in any state, including on the same cycle that the shadow is drained; ready is combinational on the drain.
- i_abort in START/WARM/RUN:
  - The next state is STOP with o_lane_stop = 1.
  - o_bit_valid is forced to 0 from the abort cycle onward, and o_bit_last is never asserted for the aborted stream.
  - The shadow is cleared, and STOP then returns to IDLE.
  - i_abort in IDLE/STOP: clears the shadow only.
  - Abort wins over a simultaneous input transfer: the vector is dropped.
- Simultaneous o_bit_last and incoming transfer: the vector is accepted and used in the following STOP.
- CNT_W wrap is impossible because the counter is reset on entry to RUN.

Optional Feature:
- Macro SNG_SCHED_PERF_EN.
- Defined: adds outputs o_stream_cnt[15:0] (completed, non-aborted streams) and o_abort_cnt[15:0]. Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package sng_pkg: state enum sch_state_t (IDLE, START, WARM, RUN, STOP), default XW = 4, STREAM_LEN = 16.
- One natural sub-module: sn_operand_shadow. It holds the shadow register plus full flag, with load/drain/clear inputs and the ready output.

Test Plan:
1. Reset then idle: no valid inputs for 20 cycles -> o_x_ready = 1, o_busy = 0, all pulses 0.
2. Single vector 0x8765_4321 (N_LANE = 8) -> o_lane_start 1 cycle after accept; o_bit_valid high for exactly 16 consecutive cycles starting START_LAT+1 cycles after start; o_bit_last on the 16th; o_lane_stop the cycle after; o_lane_x = 0x87654321 throughout.
3. Back-to-back: second vector offered during RUN of the first -> accepted immediately. The next o_lane_start follows o_lane_stop by one cycle, o_bit_valid gap = 4 cycles at START_LAT = 2, and the second stream's o_lane_x = second vector.
4. Backpressure: three vectors offered continuously -> the third waits with o_x_ready = 0 until the first stream's STOP cycle, and no vector is lost or duplicated.
5. Abort at RUN bit 5 with the shadow full -> o_bit_valid drops that cycle, no o_bit_last, o_lane_stop one cycle later, then IDLE with o_x_ready = 1. With SNG_SCHED_PERF_EN: o_abort_cnt = 1, o_stream_cnt unchanged.
6. Async reset asserted mid-WARM -> all outputs reach reset values without a clock edge, and the next accepted vector runs a full 16-bit stream.
